gpio_ctrl: RTL and testbench

//   Parametrised memory-mapped GPIO controller. Replaces the write-only 8-bit GPIO latch on the SoC bus at base 0x40000000.

---
 rtl/gpio_pkg.sv | 26 ++
 rtl/gpio_sync.sv | 29 ++
 rtl/gpio_ctrl.sv | 117 +++++++++++
 tb/tb_gpio_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register offsets, bus size encodings and write-mask helper for gpio_ctrl
package gpio_pkg;

   localparam logic [2:0] GPIO_OUT     = 3'd0;
   localparam logic [2:0] GPIO_DIR     = 3'd1;
   localparam logic [2:0] GPIO_IN      = 3'd2;
   localparam logic [2:0] GPIO_RISE_EN = 3'd3;
   localparam logic [2:0] GPIO_FALL_EN = 3'd4;
   localparam logic [2:0] GPIO_PEND    = 3'd5;
   localparam logic [2:0] GPIO_SET     = 3'd6;
   localparam logic [2:0] GPIO_CLR     = 3'd7;

   localparam logic [1:0] WSIZE_BYTE = 2'b01;
   localparam logic [1:0] WSIZE_HALF = 2'b10;
   localparam logic [1:0] WSIZE_WORD = 2'b11;

   // 2'b00 is not issued by the CPU; treat it as a full-word write.
   function automatic logic [31:0] wsize_mask(input logic [1:0] wsize);
      case (wsize)
         WSIZE_BYTE: return 32'h0000_00FF;
         WSIZE_HALF: return 32'h0000_FFFF;
         default:    return 32'hFFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/gpio_sync.sv
// rtl/gpio_sync.sv - per-bit flop-chain synchroniser for asynchronous pad inputs
module gpio_sync #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] s
);

   logic [WIDTH-1:0] r_chain [SYNC_STAGES];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            r_chain[i] <= '0;
         end
      end else begin
         r_chain[0] <= d;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            r_chain[i] <= r_chain[i-1];
         end
      end
   end

   assign s = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_ctrl.sv
// rtl/gpio_ctrl.sv - memory-mapped GPIO controller with direction, set/clear and edge interrupts
module gpio_ctrl
   import gpio_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      addr,
   input  logic             ren,
   output logic [31:0]      rdata,
   input  logic             wen,
   input  logic [31:0]      wdata,
   input  logic [1:0]       wsize,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_dir;
   logic [WIDTH-1:0] r_rise_en;
   logic [WIDTH-1:0] r_fall_en;
   logic [WIDTH-1:0] r_pend;
   logic [WIDTH-1:0] r_prev;
   logic [31:0]      r_rdata;

   logic [2:0]       w_sel;
   logic [31:0]      w_mask;
   logic [WIDTH-1:0] w_wd;
   logic [WIDTH-1:0] w_s;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;
   logic [WIDTH-1:0] w_w1c;
   logic [31:0]      w_rd_val;
   logic             w_unused_addr;

   assign w_sel         = addr[4:2];
   assign w_unused_addr = ^{addr[31:5], addr[1:0]};
   assign w_mask        = wsize_mask(wsize);
   // Bits at or above WIDTH are dropped here, so every register ignores them.
   assign w_wd          = WIDTH'(wdata & w_mask);

   gpio_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (gpio_in),
      .s     (w_s)
   );

   assign w_rise = w_s & ~r_prev & r_rise_en;
   assign w_fall = ~w_s & r_prev & r_fall_en;
   assign w_w1c  = (wen && (w_sel == GPIO_PEND)) ? w_wd : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_out     <= OUT_RESET;
         r_dir     <= '0;
         r_rise_en <= '0;
         r_fall_en <= '0;
      end else if (wen) begin
         case (w_sel)
            GPIO_OUT:     r_out     <= (r_out & ~WIDTH'(w_mask)) | w_wd;
            GPIO_DIR:     r_dir     <= (r_dir & ~WIDTH'(w_mask)) | w_wd;
            GPIO_RISE_EN: r_rise_en <= (r_rise_en & ~WIDTH'(w_mask)) | w_wd;
            GPIO_FALL_EN: r_fall_en <= (r_fall_en & ~WIDTH'(w_mask)) | w_wd;
            GPIO_SET:     r_out     <= r_out | w_wd;
            GPIO_CLR:     r_out     <= r_out & ~w_wd;
            default: ;
         endcase
      end
   end

   // New edges are OR-ed in after the clear so a coincident edge stays pending.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev <= '0;
         r_pend <= '0;
      end else begin
         r_prev <= w_s;
         r_pend <= (r_pend & ~w_w1c) | w_rise | w_fall;
      end
   end

   always_comb begin
      w_rd_val = '0;
      case (w_sel)
         GPIO_OUT:     w_rd_val = 32'(r_out);
         GPIO_DIR:     w_rd_val = 32'(r_dir);
         GPIO_IN:      w_rd_val = 32'(w_s);
         GPIO_RISE_EN: w_rd_val = 32'(r_rise_en);
         GPIO_FALL_EN: w_rd_val = 32'(r_fall_en);
         GPIO_PEND:    w_rd_val = 32'(r_pend);
         default:      w_rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rdata <= '0;
      end else if (ren) begin
         r_rdata <= w_rd_val;
      end
   end

   assign rdata    = r_rdata;
   assign gpio_out = r_out;
   assign gpio_oe  = r_dir;
   assign irq      = |r_pend;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb/tb_gpio_ctrl.sv - directed self-checking bench for gpio_ctrl
module tb_gpio_ctrl;
   import gpio_pkg::*;

   localparam int         WIDTH = 8;
   localparam int         SYNC  = 2;
   localparam logic [7:0] ORST  = 8'hA5;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic        ren;
   logic [31:0] rdata;
   logic        wen;
   logic [31:0] wdata;
   logic [1:0]  wsize;
   logic [7:0]  gpio_in;
   logic [7:0]  gpio_out;
   logic [7:0]  gpio_oe;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   gpio_ctrl #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC),
      .OUT_RESET   (ORST)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .addr     (addr),
      .ren      (ren),
      .rdata    (rdata),
      .wen      (wen),
      .wdata    (wdata),
      .wsize    (wsize),
      .gpio_in  (gpio_in),
      .gpio_out (gpio_out),
      .gpio_oe  (gpio_oe),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] reg_addr(input logic [2:0] r);
      return 32'h4000_0000 | {27'd0, r, 2'b00};
   endfunction

   task automatic bus_write(input logic [2:0] r, input logic [31:0] d, input logic [1:0] sz);
      @(negedge clk);
      wen   = 1'b1;
      addr  = reg_addr(r) | 32'h3;
      wdata = d;
      wsize = sz;
      @(posedge clk);
      #1;
      wen = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] r, output logic [31:0] d);
      @(negedge clk);
      ren  = 1'b1;
      addr = reg_addr(r);
      @(posedge clk);
      #1;
      ren = 1'b0;
      d   = rdata;
   endtask

   task automatic read_check(input string tag, input logic [2:0] r, input logic [31:0] exp);
      logic [31:0] d;
      bus_read(r, d);
      check_eq(tag, d, exp);
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rst_exp [8];
      rst_exp = '{32'hA5, 0, 0, 0, 0, 0, 0, 0};

      reset = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0;
      wsize = WSIZE_WORD; gpio_in = '0;
      settle(3);
      @(negedge clk);
      reset = 1'b0;

      // 1: reset state
      check_eq("rst_gpio_out", 32'(gpio_out), 32'hA5);
      check_eq("rst_gpio_oe", 32'(gpio_oe), 32'h00);
      check_eq("rst_irq", 32'(irq), 32'h0);
      check_eq("rst_rdata", rdata, 32'h0);
      for (int i = 0; i < 8; i++) begin
         read_check($sformatf("rst_reg%0d", i), 3'(i), rst_exp[i]);
      end

      // 2: word write, set, clear, byte/half masking, read-during-write
      bus_write(GPIO_OUT, 32'h0F, WSIZE_WORD);
      bus_write(GPIO_SET, 32'h30, WSIZE_WORD);
      bus_write(GPIO_CLR, 32'h03, WSIZE_WORD);
      read_check("out_set_clr", GPIO_OUT, 32'h3C);
      check_eq("gpio_out_3c", 32'(gpio_out), 32'h3C);
      bus_write(GPIO_DIR, 32'h1FF, WSIZE_BYTE);
      read_check("dir_byte", GPIO_DIR, 32'hFF);
      check_eq("gpio_oe_ff", 32'(gpio_oe), 32'hFF);
      bus_write(GPIO_OUT, 32'hAB00, WSIZE_HALF);
      read_check("out_half_hi", GPIO_OUT, 32'h00);
      bus_write(GPIO_OUT, 32'h1C3, WSIZE_BYTE);
      check_eq("gpio_out_c3", 32'(gpio_out), 32'hC3);
      @(negedge clk);
      ren = 1'b1; wen = 1'b1; addr = reg_addr(GPIO_OUT); wdata = 32'h11; wsize = WSIZE_WORD;
      @(posedge clk);
      #1;
      ren = 1'b0; wen = 1'b0;
      check_eq("rw_same_cycle", rdata, 32'hC3);
      read_check("out_after_rw", GPIO_OUT, 32'h11);
      bus_write(GPIO_DIR, 32'h0, WSIZE_WORD);

      // 3: rising edge on bit 0
      bus_write(GPIO_RISE_EN, 32'h01, WSIZE_WORD);
      @(negedge clk);
      gpio_in = 8'h01;
      settle(SYNC);
      check_eq("irq_before_pend", 32'(irq), 32'h0);
      read_check("in_after_sync", GPIO_IN, 32'h01);
      check_eq("irq_rise", 32'(irq), 32'h1);
      read_check("pend_rise", GPIO_PEND, 32'h01);
      bus_write(GPIO_PEND, 32'h01, WSIZE_WORD);
      read_check("pend_w1c", GPIO_PEND, 32'h00);
      check_eq("irq_w1c", 32'(irq), 32'h0);

      // 4: falling edge on bit 3, before and after enabling
      @(negedge clk); gpio_in = 8'h09; settle(4);
      @(negedge clk); gpio_in = 8'h01; settle(4);
      read_check("fall_disabled", GPIO_PEND, 32'h00);
      bus_write(GPIO_FALL_EN, 32'h08, WSIZE_WORD);
      settle(2);
      read_check("fall_no_retro", GPIO_PEND, 32'h00);
      @(negedge clk); gpio_in = 8'h09; settle(4);
      @(negedge clk); gpio_in = 8'h01; settle(4);
      read_check("fall_enabled", GPIO_PEND, 32'h08);
      bus_write(GPIO_PEND, 32'hFF, WSIZE_WORD);

      // 5: edge coincident with W1C of the same bit
      @(negedge clk); gpio_in = 8'h00; settle(4);
      bus_write(GPIO_PEND, 32'hFF, WSIZE_WORD);
      read_check("pend_clean", GPIO_PEND, 32'h00);
      @(negedge clk);
      gpio_in = 8'h01;
      @(posedge clk);
      @(posedge clk);
      bus_write(GPIO_PEND, 32'h01, WSIZE_WORD);
      check_eq("set_wins_irq", 32'(irq), 32'h1);
      read_check("set_wins_pend", GPIO_PEND, 32'h01);

      // 6: reset with all bits pending and a read in flight
      @(negedge clk); gpio_in = 8'h00; settle(4);
      bus_write(GPIO_FALL_EN, 32'h00, WSIZE_WORD);
      bus_write(GPIO_PEND, 32'hFF, WSIZE_WORD);
      bus_write(GPIO_RISE_EN, 32'hFF, WSIZE_WORD);
      @(negedge clk); gpio_in = 8'hFF; settle(4);
      read_check("pend_all", GPIO_PEND, 32'hFF);
      @(negedge clk);
      ren = 1'b1; addr = reg_addr(GPIO_PEND); reset = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rst_mid_rdata", rdata, 32'h0);
      check_eq("rst_mid_irq", 32'(irq), 32'h0);
      check_eq("rst_mid_out", 32'(gpio_out), 32'hA5);
      @(negedge clk);
      ren = 1'b0; reset = 1'b0;
      settle(4);
      read_check("rst_mid_pend", GPIO_PEND, 32'h00);
      read_check("rst_mid_rise_en", GPIO_RISE_EN, 32'h00);
      read_check("rst_mid_in", GPIO_IN, 32'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
